// File: rtl/rob_multiport.sv
// Multi-ported reorder buffer: WIDTH-wide in-order allocate and commit around a
// circular buffer of DEPTH entries, with CDB_PORTS out-of-order completion writes.
module rob_multiport #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 2,
  parameter int CDB_PORTS = 2,
  parameter int PAYLOAD_W = 64,
  parameter int RESULT_W  = 40,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int PC_W     = $clog2(WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              push_valid,
  input  logic [WIDTH*PAYLOAD_W-1:0]    push_data,
  output logic                          push_ready,
  output logic [WIDTH*IDX_W-1:0]        push_index,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*IDX_W-1:0]    cdb_index,
  input  logic [CDB_PORTS*RESULT_W-1:0] cdb_result,
  output logic [WIDTH-1:0]              head_valid,
  output logic [WIDTH*IDX_W-1:0]        head_index,
  output logic [WIDTH*PAYLOAD_W-1:0]    head_data,
  output logic [WIDTH*RESULT_W-1:0]     head_result,
  input  logic [PC_W-1:0]               pop_count,
  output logic [IDX_W:0]                count,
  output logic                          empty,
  output logic                          full
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] WIDTH_C = (IDX_W + 1)'(WIDTH);

  // Handshakes: push lanes are taken only when push_valid and push_ready are both
  // high at a clock edge, all lanes or none; push_ready depends on registered state
  // only. Commit is a count, not a handshake: pop_count asks for up to that many
  // leading head_valid lanes and the surplus is silently clamped.

  logic [IDX_W:0]          head;
  logic [IDX_W:0]          tail;
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        done;
  logic [PAYLOAD_W-1:0]    payload_mem [DEPTH];
  logic [RESULT_W-1:0]     result_mem  [DEPTH];

  logic [IDX_W-1:0]        push_slot [WIDTH];
  logic [IDX_W-1:0]        head_slot [WIDTH];
  logic [IDX_W:0]          free_cnt;
  logic [PC_W-1:0]         push_n;
  logic                    push_fire;
  logic [PC_W-1:0]         lead_n;
  logic [PC_W-1:0]         pop_eff;
  logic                    chain;
  logic [DEPTH-1:0]        push_mask;
  logic [DEPTH-1:0]        pop_mask;
  logic [DEPTH-1:0]        cdb_hit;
  logic [DEPTH-1:0]        cdb_wr;
  logic [RESULT_W-1:0]     cdb_res [DEPTH];
  logic [IDX_W-1:0]        cdb_slot;

  function automatic logic [PC_W-1:0] ones(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  // Occupancy, all from the registered pointers.
  assign count      = tail - head;
  assign free_cnt   = DEPTH_C - count;
  assign push_ready = (free_cnt >= WIDTH_C);
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign push_n     = ones(push_valid);
  assign push_fire  = push_ready && (|push_valid);

  always_comb begin
    chain      = 1'b1;
    head_valid = '0;
    push_index = '0;
    head_index = '0;
    head_data  = '0;
    head_result = '0;
    for (int k = 0; k < WIDTH; k++) begin
      push_slot[k] = tail[IDX_W-1:0] + IDX_W'(k);
      head_slot[k] = head[IDX_W-1:0] + IDX_W'(k);
      push_index[k*IDX_W +: IDX_W] = push_slot[k];
      head_index[k*IDX_W +: IDX_W] = head_slot[k];
      head_data[k*PAYLOAD_W +: PAYLOAD_W] = payload_mem[head_slot[k]];
      head_result[k*RESULT_W +: RESULT_W] = result_mem[head_slot[k]];
      // A lane is committable only if every older lane before it is too.
      head_valid[k] = chain && ((IDX_W + 1)'(k) < count) &&
                      busy[head_slot[k]] && done[head_slot[k]];
      chain = head_valid[k];
    end
  end

  assign lead_n  = ones(head_valid);
  assign pop_eff = (pop_count < lead_n) ? pop_count : lead_n;

  always_comb begin
    push_mask = '0;
    pop_mask  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (push_fire && push_valid[k]) push_mask[push_slot[k]] = 1'b1;
      if (PC_W'(k) < pop_eff)         pop_mask[head_slot[k]]  = 1'b1;
    end
  end

  // Walk ports from highest to lowest so the lowest-numbered port overwrites last.
  always_comb begin
    cdb_hit  = '0;
    cdb_slot = '0;
    for (int e = 0; e < DEPTH; e++) cdb_res[e] = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p]) begin
        cdb_slot          = cdb_index[p*IDX_W +: IDX_W];
        cdb_hit[cdb_slot] = 1'b1;
        cdb_res[cdb_slot] = cdb_result[p*RESULT_W +: RESULT_W];
      end
    end
  end

  assign cdb_wr = cdb_hit & busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
    end else begin
      head <= head + (IDX_W + 1)'(pop_eff);
      if (push_fire) tail <= tail + (IDX_W + 1)'(push_n);
      busy <= (busy & ~pop_mask) | push_mask;
      done <= (done | cdb_wr) & ~pop_mask & ~push_mask;
    end
  end

  // Storage needs no reset: busy/done gate every use of it.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (cdb_wr[e]) result_mem[e] <= cdb_res[e];
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (push_fire && push_valid[k])
        payload_mem[push_slot[k]] <= push_data[k*PAYLOAD_W +: PAYLOAD_W];
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport: directed scenarios plus randomized traffic
// checked against an index/count model and an in-order payload scoreboard.
module tb_rob_multiport;

  localparam int DEPTH     = 16;
  localparam int WIDTH     = 2;
  localparam int CDB_PORTS = 2;
  localparam int PAYLOAD_W = 64;
  localparam int RESULT_W  = 40;
  localparam int IDX_W     = 4;
  localparam int PC_W      = 2;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic                          flush = 1'b0;
  logic [WIDTH-1:0]              push_valid = '0;
  logic [WIDTH*PAYLOAD_W-1:0]    push_data = '0;
  logic                          push_ready;
  logic [WIDTH*IDX_W-1:0]        push_index;
  logic [CDB_PORTS-1:0]          cdb_valid = '0;
  logic [CDB_PORTS*IDX_W-1:0]    cdb_index = '0;
  logic [CDB_PORTS*RESULT_W-1:0] cdb_result = '0;
  logic [WIDTH-1:0]              head_valid;
  logic [WIDTH*IDX_W-1:0]        head_index;
  logic [WIDTH*PAYLOAD_W-1:0]    head_data;
  logic [WIDTH*RESULT_W-1:0]     head_result;
  logic [PC_W-1:0]               pop_count = '0;
  logic [IDX_W:0]                count;
  logic                          empty;
  logic                          full;

  rob_multiport #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .CDB_PORTS(CDB_PORTS),
    .PAYLOAD_W(PAYLOAD_W), .RESULT_W(RESULT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .push_index(push_index),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_result(cdb_result),
    .head_valid(head_valid), .head_index(head_index), .head_data(head_data),
    .head_result(head_result), .pop_count(pop_count),
    .count(count), .empty(empty), .full(full)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rst && !flush)
      assert ((push_valid & (push_valid + 1'b1)) == '0)
        else $error("push_valid lanes not contiguous: %b", push_valid);
  end

  // Reference model: entries in program order, indexed by (head + age) mod DEPTH
  int                   m_head;
  int                   m_count;
  bit                   m_busy [DEPTH];
  bit                   m_done [DEPTH];
  logic [RESULT_W-1:0]  m_res  [DEPTH];
  logic [PAYLOAD_W-1:0] exp_q[$];
  int                   n_checks = 0;
  int                   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_head = 0;
    m_count = 0;
    for (int e = 0; e < DEPTH; e++) begin
      m_busy[e] = 1'b0;
      m_done[e] = 1'b0;
      m_res[e]  = '0;
    end
    exp_q.delete();
  endtask

  function automatic int model_lead();
    int l = 0;
    for (int k = 0; k < WIDTH; k++)
      if (k < m_count && m_done[(m_head + k) % DEPTH] && l == k) l++;
    return l;
  endfunction

  task automatic check_outputs();
    int lead;
    logic [WIDTH-1:0] ehv;
    lead = model_lead();
    ehv = '0;
    for (int k = 0; k < lead; k++) ehv[k] = 1'b1;
    check("head_valid", 64'(head_valid), 64'(ehv));
    check("count", 64'(count), 64'(m_count));
    check("empty", 64'(empty), 64'(m_count == 0));
    check("full", 64'(full), 64'(m_count == DEPTH));
    check("push_ready", 64'(push_ready), 64'((DEPTH - m_count) >= WIDTH));
    for (int k = 0; k < WIDTH; k++) begin
      check("push_index", 64'(push_index[k*IDX_W +: IDX_W]), 64'((m_head + m_count + k) % DEPTH));
      check("head_index", 64'(head_index[k*IDX_W +: IDX_W]), 64'((m_head + k) % DEPTH));
      if (k < lead) begin
        check("head_data", head_data[k*PAYLOAD_W +: PAYLOAD_W], exp_q[k]);
        check("head_result", 64'(head_result[k*RESULT_W +: RESULT_W]),
              64'(m_res[(m_head + k) % DEPTH]));
      end
    end
  endtask

  // Applies the inputs sampled at a rising edge to the model.
  task automatic model_update();
    int lead, eff, n, old_count, idx;
    bit taken [DEPTH];
    if (flush) begin
      model_reset();
      return;
    end
    for (int e = 0; e < DEPTH; e++) taken[e] = 1'b0;
    lead = model_lead();
    eff = (int'(pop_count) < lead) ? int'(pop_count) : lead;
    old_count = m_count;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p]) begin
        idx = int'(cdb_index[p*IDX_W +: IDX_W]);
        if (m_busy[idx] && !taken[idx]) begin
          m_done[idx] = 1'b1;
          m_res[idx]  = cdb_result[p*RESULT_W +: RESULT_W];
        end
        taken[idx] = 1'b1;
      end
    end
    for (int i = 0; i < eff; i++) begin
      idx = (m_head + i) % DEPTH;
      m_busy[idx] = 1'b0;
      m_done[idx] = 1'b0;
      void'(exp_q.pop_front());
    end
    n = 0;
    if ((DEPTH - old_count) >= WIDTH) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (push_valid[k]) begin
          idx = (m_head + old_count + k) % DEPTH;
          m_busy[idx] = 1'b1;
          m_done[idx] = 1'b0;
          exp_q.push_back(push_data[k*PAYLOAD_W +: PAYLOAD_W]);
          n++;
        end
      end
    end
    m_head  = (m_head + eff) % DEPTH;
    m_count = old_count - eff + n;
  endtask

  // Driver tasks: called at a falling edge, tick() checks, clocks and returns at the next falling edge.
  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    flush = 1'b0;
    push_valid = '0;
    cdb_valid = '0;
    pop_count = '0;
  endtask

  task automatic drive_push(input int n);
    push_valid = '0;
    for (int k = 0; k < WIDTH; k++) begin
      push_data[k*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom};
      if (k < n) push_valid[k] = 1'b1;
    end
  endtask

  task automatic drive_cdb(input int p, input int idx, input logic [RESULT_W-1:0] r);
    cdb_valid[p] = 1'b1;
    cdb_index[p*IDX_W +: IDX_W] = IDX_W'(idx);
    cdb_result[p*RESULT_W +: RESULT_W] = r;
  endtask

  function automatic logic [RESULT_W-1:0] rand_res();
    return RESULT_W'({$urandom, $urandom});
  endfunction

  task automatic random_cdb();
    int pend[$];
    for (int i = 0; i < m_count; i++)
      if (!m_done[(m_head + i) % DEPTH]) pend.push_back((m_head + i) % DEPTH);
    for (int p = 0; p < CDB_PORTS; p++) begin
      if ($urandom_range(0, 4) != 0) begin
        if (pend.size() > 0 && $urandom_range(0, 5) != 0)
          drive_cdb(p, pend[$urandom_range(0, pend.size() - 1)], rand_res());
        else
          drive_cdb(p, $urandom_range(0, DEPTH - 1), rand_res());
      end
    end
  endtask

  task automatic flush_cycle();
    drive_idle();
    flush = 1'b1;
    tick();
    drive_idle();
  endtask

  logic [RESULT_W-1:0] res_a;
  logic [RESULT_W-1:0] res_b;
  int pushed;
  int cyc;
  int n;

  initial begin
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_head_valid", 64'(head_valid), 64'h0);
    check("rst_push_index", 64'(push_index), 64'h10);
    rst = 1'b1;
    tick();

    // Fill to full, then one more push must be dropped
    for (int i = 0; i < 8; i++) begin
      drive_push(2);
      tick();
    end
    drive_idle();
    check("t1_full", 64'(full), 64'h1);
    check("t1_push_ready", 64'(push_ready), 64'h0);
    check("t1_count", 64'(count), 64'd16);
    drive_push(2);
    tick();
    drive_idle();
    check("t1_drop_count", 64'(count), 64'd16);
    flush_cycle();

    // Out-of-order completion blocks commit until the oldest is done
    drive_push(2);
    tick();
    drive_idle();
    drive_cdb(0, 1, rand_res());
    tick();
    drive_idle();
    check("t2_hv_00", 64'(head_valid), 64'h0);
    drive_cdb(0, 0, rand_res());
    tick();
    drive_idle();
    check("t2_hv_11", 64'(head_valid), 64'h3);
    flush_cycle();

    // Pop request larger than the committable prefix is clamped
    drive_push(2);
    tick();
    drive_idle();
    drive_cdb(1, 0, rand_res());
    tick();
    drive_idle();
    check("t3_hv_01", 64'(head_valid), 64'h1);
    pop_count = 2'd2;
    tick();
    drive_idle();
    check("t3_count", 64'(count), 64'd1);
    check("t3_head_index", 64'(head_index[IDX_W-1:0]), 64'd1);
    flush_cycle();

    // Same-index CDB collision and CDB to a free entry
    res_a = rand_res();
    res_b = ~res_a;
    drive_push(2);
    tick();
    drive_push(2);
    tick();
    drive_idle();
    drive_cdb(0, 3, res_a);
    drive_cdb(1, 3, res_b);
    tick();
    drive_idle();
    drive_cdb(0, 4, rand_res());
    tick();
    drive_idle();
    drive_push(2);
    drive_cdb(0, 0, rand_res());
    drive_cdb(1, 1, rand_res());
    tick();
    drive_idle();
    drive_cdb(0, 2, rand_res());
    tick();
    drive_idle();
    pop_count = 2'd2;
    tick();
    drive_idle();
    check("t5_port0_wins", 64'(head_result[RESULT_W +: RESULT_W]), 64'(res_a));
    pop_count = 2'd2;
    tick();
    drive_idle();
    check("t5_nonbusy_ignored", 64'(head_valid), 64'h0);
    drive_cdb(0, 4, rand_res());
    tick();
    drive_idle();

    // Flush beats a same-cycle push, CDB write and pop
    flush = 1'b1;
    drive_push(2);
    drive_cdb(0, 5, rand_res());
    pop_count = 2'd2;
    tick();
    drive_idle();
    check("t6_count", 64'(count), 64'h0);
    check("t6_empty", 64'(empty), 64'h1);
    check("t6_push_index", 64'(push_index), 64'h10);
    check("t6_head_valid", 64'(head_valid), 64'h0);

    // Random fill/drain of 40 entries with wrap-around
    pushed = 0;
    cyc = 0;
    while ((pushed < 40 || m_count > 0) && cyc < 600) begin
      drive_idle();
      if (pushed < 40) begin
        n = $urandom_range(0, 2);
        if (n > 40 - pushed) n = 40 - pushed;
        if ((DEPTH - m_count) >= WIDTH) pushed += n;
        drive_push(n);
      end
      random_cdb();
      pop_count = PC_W'($urandom_range(0, 3));
      tick();
      cyc++;
    end
    drive_idle();
    check("t4_drained", 64'(count), 64'h0);
    check("t4_pushed", 64'(pushed), 64'd40);

    // Longer random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      drive_idle();
      drive_push($urandom_range(0, 2));
      random_cdb();
      pop_count = PC_W'($urandom_range(0, 3));
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a burst
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      drive_push(2);
      random_cdb();
      pop_count = PC_W'($urandom_range(0, 2));
      tick();
    end
    drive_push(2);
    random_cdb();
    #2;
    rst = 1'b0;
    #1;
    check("arst_head_valid", 64'(head_valid), 64'h0);
    check("arst_count", 64'(count), 64'h0);
    check("arst_empty", 64'(empty), 64'h1);
    check("arst_full", 64'(full), 64'h0);
    check("arst_push_ready", 64'(push_ready), 64'h1);
    check("arst_push_index", 64'(push_index), 64'h10);
    check("arst_head_index", 64'(head_index), 64'h10);
    model_reset();
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive_push(2);
    tick();
    drive_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
